// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller.
//   state_e : controller states
//   mode_e  : run mode as presented on the mode input
//   cause_e : halt reason reported on halt_cause
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_BURST     = 3'd2,
    ST_WAIT_STEP = 3'd3,
    ST_STEP      = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_STEP     = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_STEP_ALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_HOST       = 3'd1,
    CAUSE_BREAKPOINT = 3'd2,
    CAUSE_TIMEOUT    = 3'd3,
    CAUSE_BURST_DONE = 3'd4
  } cause_e;

endpackage

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint comparator array.
//   pc      : current fetch PC
//   bp_addr : NUM_BP packed breakpoint addresses, slot i at [i*PC_W +: PC_W]
//   bp_en   : per-slot enable
//   hit     : any enabled slot equals pc (combinational)
module bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   hit
);

  // OR-reduce the per-slot address matches
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit = hit | (bp_en[i] & (pc == bp_addr[i*PC_W +: PC_W]));
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: free-run, single-step and burst execution with
// breakpoints, cycle timeout and host halt.
//   clk, rst          : clock, synchronous active-high reset
//   mode, start, step : run mode, start/resume pulse, step level input
//   halt_req          : host stop request
//   burst_len         : burst cycle count (sampled on start)
//   max_cycles        : timeout limit compared live, 0 disables
//   pc, bp_addr, bp_en: fetch PC and breakpoint slots
//   cpu_en            : CPU clock enable (combinational)
//   halted            : high in HALT
//   halt_cause        : reason for the last halt
//   cycle_count       : saturating count of enabled CPU cycles
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16,
  parameter int NUM_BP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   start,
  input  logic                   step,
  input  logic                   halt_req,
  input  logic [BURST_W-1:0]     burst_len,
  input  logic [CNT_W-1:0]       max_cycles,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [2:0]             halt_cause,
  output logic [CNT_W-1:0]       cycle_count
);

  state_e             state, state_nxt;
  cause_e             last_cause, cause_nxt;
  logic [BURST_W-1:0] remain, remain_nxt;
  logic               skip, skip_nxt;
  logic               step_q;
  logic               bp_raw;
  logic               bp_hit;
  logic               run_state;
  logic               step_edge;
  logic               timeout;
  logic               burst_done;
  logic [CNT_W-1:0]   cnt_inc;

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (pc),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .hit     (bp_raw)
  );

  // skip masks the breakpoint at the resume PC so execution can move past it
  assign bp_hit     = bp_raw & ~skip;
  assign run_state  = (state == ST_RUN) | (state == ST_BURST) | (state == ST_STEP);
  assign cpu_en     = run_state & ~bp_hit;
  assign step_edge  = step & ~step_q;
  assign cnt_inc    = (&cycle_count) ? cycle_count
                                     : cycle_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout    = cpu_en & (max_cycles != {CNT_W{1'b0}}) & (cnt_inc == max_cycles);
  assign burst_done = cpu_en & (state == ST_BURST) & (remain == {{(BURST_W-1){1'b0}}, 1'b1});
  assign halted     = (state == ST_HALT);
  assign halt_cause = last_cause;

  // next-state, cause, remain and skip selection
  always_comb begin
    state_nxt = state;
    cause_nxt = last_cause;
    skip_nxt  = skip & ~cpu_en;
    if (cpu_en && (state == ST_BURST)) begin
      remain_nxt = remain - {{(BURST_W-1){1'b0}}, 1'b1};
    end else begin
      remain_nxt = remain;
    end

    if (halt_req && (state != ST_HALT)) begin
      // host request outranks everything, including a same-cycle start
      state_nxt = ST_HALT;
      cause_nxt = CAUSE_HOST;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            cause_nxt = CAUSE_NONE;
            skip_nxt  = 1'b1;
            case (mode_e'(mode))
              MODE_FREE: state_nxt = ST_RUN;
              MODE_BURST: begin
                remain_nxt = burst_len;
                if (burst_len == {BURST_W{1'b0}}) begin
                  state_nxt = ST_HALT;
                  cause_nxt = CAUSE_BURST_DONE;
                end else begin
                  state_nxt = ST_BURST;
                end
              end
              default: state_nxt = ST_WAIT_STEP;
            endcase
          end else begin
            state_nxt = state;
          end
        end
        ST_RUN, ST_BURST, ST_STEP: begin
          if (bp_hit) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_BREAKPOINT;
          end else if (timeout) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_TIMEOUT;
          end else if (burst_done) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_BURST_DONE;
          end else if (state == ST_STEP) begin
            state_nxt = ST_WAIT_STEP;
          end else begin
            state_nxt = state;
          end
        end
        ST_WAIT_STEP: begin
          if (step_edge) begin
            state_nxt = ST_STEP;
            skip_nxt  = 1'b1;
          end else begin
            state_nxt = state;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cause_nxt = CAUSE_NONE;
        end
      endcase
    end
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_cause  <= CAUSE_NONE;
      remain      <= {BURST_W{1'b0}};
      skip        <= 1'b0;
      step_q      <= 1'b0;
      cycle_count <= {CNT_W{1'b0}};
    end else begin
      state       <= state_nxt;
      last_cause  <= cause_nxt;
      remain      <= remain_nxt;
      skip        <= skip_nxt;
      step_q      <= step;
      cycle_count <= cpu_en ? cnt_inc : cycle_count;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int PC_W = 32, CNT_W = 32, BURST_W = 16, NUM_BP = 4;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic start = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [CNT_W-1:0] max_cycles = '0;
  logic [PC_W-1:0] pc = '0;
  logic [NUM_BP*PC_W-1:0] bp_addr = '0;
  logic [NUM_BP-1:0] bp_en = '0;
  logic cpu_en, halted;
  logic [2:0] halt_cause;
  logic [CNT_W-1:0] cycle_count;

  int checks = 0, failures = 0;
  int dut_pulses = 0;
  bit pc_auto = 1'b0;

  // behavioural model: phase 0 idle, 1 halted, 2 active; kind 0 free, 1 step, 2 burst
  int m_phase, m_kind, m_left, m_cause;
  bit m_live, m_skip, m_prev_step;
  longint m_count;

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .BURST_W(BURST_W), .NUM_BP(NUM_BP)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .step(step), .halt_req(halt_req),
    .burst_len(burst_len), .max_cycles(max_cycles), .pc(pc), .bp_addr(bp_addr),
    .bp_en(bp_en), .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause),
    .cycle_count(cycle_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bp();
    bit h = 1'b0;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) h = 1'b1;
    return h;
  endfunction

  function automatic bit model_ready();
    return (m_phase == 2) && (m_kind != 1 || m_live);
  endfunction

  function automatic bit model_en();
    return model_ready() && !(model_bp() && !m_skip);
  endfunction

  task automatic model_step();
    bit en, hit, tmo, bdone, sedge;
    longint nxt;
    en    = model_en();
    hit   = model_ready() && model_bp() && !m_skip;
    nxt   = (m_count == MAXC) ? m_count : m_count + 1;
    tmo   = en && (max_cycles != 0) && (nxt == longint'(max_cycles));
    bdone = en && (m_kind == 2) && (m_left == 1);
    sedge = step && !m_prev_step;
    m_prev_step = step;
    if (rst) begin
      m_phase = 0; m_kind = 0; m_left = 0; m_cause = 0;
      m_live = 0; m_skip = 0; m_prev_step = 0; m_count = 0;
      return;
    end
    if (en) begin
      m_count = nxt;
      m_skip  = 0;
      if (m_kind == 2) m_left--;
    end
    if (halt_req && m_phase != 1) begin
      m_phase = 1; m_cause = 1; m_live = 0;
    end else if (m_phase != 2) begin
      if (start) begin
        m_cause = 0; m_skip = 1; m_live = 0;
        m_kind  = (mode == 2'd0) ? 0 : (mode == 2'd2) ? 2 : 1;
        m_phase = 2;
        if (m_kind == 2) begin
          m_left = int'(burst_len);
          if (burst_len == 0) begin m_phase = 1; m_cause = 4; end
        end
      end
    end else if (hit) begin
      m_phase = 1; m_cause = 2; m_live = 0;
    end else if (tmo) begin
      m_phase = 1; m_cause = 3; m_live = 0;
    end else if (bdone) begin
      m_phase = 1; m_cause = 4;
    end else if (m_kind == 1) begin
      if (m_live) m_live = 0;
      else if (sedge) begin m_live = 1; m_skip = 1; end
    end
  endtask

  // one clock: compare at negedge, advance model at posedge, then let inputs change
  task automatic cyc();
    bit en;
    @(negedge clk);
    en = model_en();
    chk("cpu_en", cpu_en, en);
    chk("halted", halted, m_phase == 1);
    chk("halt_cause", halt_cause, m_cause);
    chk("cycle_count", cycle_count, m_count);
    if (cpu_en === 1'b1) dut_pulses++;
    @(posedge clk);
    model_step();
    #1;
    if (pc_auto && en) pc = pc + 32'd4;
  endtask

  task automatic idle_inputs();
    start = 0; step = 0; halt_req = 0; bp_en = '0; pc = '0; pc_auto = 0;
    max_cycles = '0; burst_len = '0; mode = 2'b00; bp_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); rst = 0; dut_pulses = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic run_until_halt(input int limit, input string name);
    int n = 0;
    while (m_phase != 1 && n < limit) begin cyc(); n++; end
    if (m_phase != 1) begin
      failures++; checks++;
      $display("FAIL %s bound expired after %0d cycles", name, limit);
    end
  endtask

  initial begin
    // first reset without comparisons (outputs are unknown before it)
    idle_inputs();
    rst = 1;
    @(posedge clk); model_step(); #1;
    rst = 0;
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_halted", halted, 0);
    chk("reset_cause", halt_cause, 0);
    chk("reset_count", cycle_count, 0);

    // burst of 5
    mode = 2'b10; burst_len = 16'd5; pulse_start();
    repeat (8) cyc();
    chk("burst_pulses", dut_pulses, 5);
    chk("burst_halted", halted, 1);
    chk("burst_cause", halt_cause, 4);
    chk("burst_count", cycle_count, 5);
    chk("model_burst_count", m_count, 5);

    // single step
    idle_inputs(); do_reset();
    mode = 2'b01; pulse_start(); repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      step = 1; cyc(); step = 0; repeat (3) cyc();
    end
    chk("step_pulses", dut_pulses, 3);
    dut_pulses = 0;
    step = 1; repeat (8) cyc(); step = 0; repeat (2) cyc();
    chk("step_held_pulses", dut_pulses, 1);
    chk("step_count", cycle_count, 4);
    halt_req = 1; cyc(); halt_req = 0; cyc();

    // breakpoint and resume
    idle_inputs(); do_reset();
    bp_addr[31:0] = 32'h40; bp_en = 4'b0001; pc_auto = 1;
    pulse_start();
    run_until_halt(40, "bp_wait");
    chk("bp_cause", halt_cause, 2);
    chk("bp_count", cycle_count, 16);
    chk("bp_pc", pc, 32'h40);
    chk("bp_cpu_en", cpu_en, 0);
    chk("model_bp_count", m_count, 16);
    pulse_start();
    repeat (5) cyc();
    chk("bp_resume_count", cycle_count, 21);
    chk("bp_resume_pc", pc, 32'h54);
    chk("bp_resume_halted", halted, 0);
    halt_req = 1; cyc(); halt_req = 0; cyc();

    // timeout, then zero-length burst
    idle_inputs(); do_reset();
    max_cycles = 32'd10; pulse_start();
    run_until_halt(30, "timeout_wait");
    chk("timeout_cause", halt_cause, 3);
    chk("timeout_count", cycle_count, 10);
    max_cycles = '0; mode = 2'b10; burst_len = 16'd0; dut_pulses = 0;
    pulse_start();
    chk("burst0_halted", halted, 1);
    chk("burst0_cause", halt_cause, 4);
    repeat (3) cyc();
    chk("burst0_pulses", dut_pulses, 0);
    chk("burst0_count", cycle_count, 10);

    // host vs breakpoint in the same cycle
    idle_inputs(); do_reset();
    bp_addr[31:0] = 32'h40; bp_en = 4'b0001; pc_auto = 1;
    pulse_start();
    for (int n = 0; n < 40 && m_phase != 1; n++) begin
      halt_req = (pc == 32'h40);
      cyc();
    end
    halt_req = 0; cyc();
    chk("prio_cause", halt_cause, 1);
    chk("prio_count", cycle_count, 16);
    // halt_req together with start in IDLE
    idle_inputs(); do_reset();
    halt_req = 1; start = 1; cyc(); halt_req = 0; start = 0; cyc();
    chk("host_idle_halted", halted, 1);
    chk("host_idle_cause", halt_cause, 1);
    chk("host_idle_pulses", dut_pulses, 0);

    // reset in the middle of a long burst
    idle_inputs(); do_reset();
    mode = 2'b10; burst_len = 16'd100; pulse_start();
    repeat (20) cyc();
    rst = 1; cyc(); rst = 0;
    chk("rst_mid_cpu_en", cpu_en, 0);
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_cause", halt_cause, 0);
    chk("rst_mid_count", cycle_count, 0);
    pulse_start(); repeat (3) cyc();
    chk("rst_restart_count", cycle_count, 3);
    chk("rst_restart_en", cpu_en, 1);

    // randomized traffic against the model
    idle_inputs(); do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        for (int i = 0; i < NUM_BP; i++) bp_addr[i*PC_W +: PC_W] = 32'($urandom_range(0, 7) * 4);
        bp_en = 4'($urandom);
      end
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 7) == 0);
      halt_req   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) step = ~step;
      mode       = 2'($urandom);
      burst_len  = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0)
        max_cycles = ($urandom_range(0, 2) == 0) ? 32'(m_count + $urandom_range(1, 5)) : 32'd0;
      pc         = 32'($urandom_range(0, 7) * 4);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL expose these parameters:
- PC_W, 32, program-counter width.
- CNT_W, 32, cycle-counter width.
- BURST_W, 16, burst-length width.
- NUM_BP, 4, number of breakpoint comparators, range 1..8.

REQ-002 The block SHALL expose these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  run mode: 00 free-run, 01 single-step, 10 burst, 11 treated as 01.
- start  in  1  one-cycle pulse; begins or resumes execution.
- step  in  1  level input; each rising edge requests one CPU cycle.
- halt_req  in  1  host stop request.
- burst_len  in  BURST_W  cycle count for burst mode.
- max_cycles  in  CNT_W  timeout limit; 0 disables the timeout.
- pc  in  PC_W  current CPU fetch PC.
- bp_addr  in  NUM_BP*PC_W  breakpoint addresses, packed; slot i is at [i*PC_W +: PC_W].
- bp_en  in  NUM_BP  per-slot breakpoint enable.
- cpu_en  out  1  CPU clock enable.
- halted  out  1  high in the HALT state.
- halt_cause  out  3  reason for the last halt.
- cycle_count  out  CNT_W  number of enabled CPU cycles.

Function
REQ-003 The controller SHALL implement states IDLE, RUN, BURST, WAIT_STEP, STEP and HALT.
REQ-004 From IDLE or HALT, a start pulse SHALL sample mode and go to:
- RUN for mode 00;
- BURST for mode 10, loading remain = burst_len;
- WAIT_STEP for mode 01 or 11.
REQ-005 Changes to mode, burst_len or max_cycles SHALL be ignored outside IDLE/HALT, except that max_cycles is compared live.
REQ-006 In BURST, a start with burst_len = 0 SHALL go directly to HALT with cause BURST_DONE, and cpu_en SHALL never assert.
REQ-007 step_q SHALL register step each cycle; a step edge is step & ~step_q.
REQ-008 In WAIT_STEP, a step edge SHALL move to STEP; STEP SHALL last exactly one cycle and return to WAIT_STEP.
REQ-009 Step edges in any other state SHALL be discarded.
REQ-010 cpu_en SHALL equal run_state & ~bp_hit, where run_state is true in RUN, BURST or STEP; cpu_en is combinational from registered state plus the pc compare.
REQ-011 bp_hit SHALL be true when any bp_en[i] is set and pc == bp_addr[i], unless the skip flag is set.
REQ-012 The skip flag SHALL be set on every start and every transition into STEP, and SHALL be cleared after the first cycle in which cpu_en = 1. This lets execution resume past a breakpoint.
REQ-013 On bp_hit in a run state, the next state SHALL be HALT with cause BREAKPOINT; the instruction at the breakpoint is not enabled.
REQ-014 cycle_count SHALL increment by 1 on every cycle with cpu_en = 1, saturate at all-ones, and be cleared only by rst.
REQ-015 If max_cycles != 0 and the incremented count equals max_cycles, the next state SHALL be HALT with cause TIMEOUT.
REQ-016 In BURST, remain SHALL decrement on each enabled cycle; an enabled cycle with remain == 1 SHALL go to HALT with cause BURST_DONE.
REQ-017 halt_req in any state except HALT SHALL go to HALT with cause HOST; this includes IDLE, and a halt_req in the same cycle as start wins.
REQ-018 When several halt conditions occur in one cycle, the priority SHALL be HOST > BREAKPOINT > TIMEOUT > BURST_DONE, and exactly one cause is recorded.
REQ-019 halt_cause SHALL be encoded as 0 NONE, 1 HOST, 2 BREAKPOINT, 3 TIMEOUT, 4 BURST_DONE.
REQ-020 halt_cause SHALL hold its value until the next accepted start, then return to NONE.
REQ-021 halted SHALL be 1 exactly while in HALT.

Reset
REQ-022 rst SHALL force the following at the next clock edge, overriding all other inputs:
- state IDLE, cpu_en 0, halted 0;
- halt_cause NONE, cycle_count 0;
- remain 0, skip 0, step_q 0.
REQ-023 rst asserted mid-run or mid-burst SHALL abandon the operation, with no halt cause recorded.

Structure
REQ-024 A shared package cpu_ctrl_pkg SHALL hold the state enum, the mode enum and the halt-cause enum with the encodings above.
REQ-025 The comparator array SHALL be a sub-module bp_match, parametrised by PC_W and NUM_BP, producing a single hit bit combinationally.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Burst: mode=10, burst_len=5, start → cpu_en high for exactly 5 cycles, then halted=1, halt_cause=4, cycle_count=5.
- Step: mode=01, start, three step rising edges each 4 cycles apart → three single-cycle cpu_en pulses; step held high produces only one pulse.
- Breakpoint: bp_addr[0]=0x40, bp_en=0001, mode=00, pc advancing by 4 per enabled cycle from 0 → halt with cpu_en=0 when pc=0x40, halt_cause=2, cycle_count=16; a second start → pc=0x40 enabled once, then run continues.
- Timeout: max_cycles=10, mode=00 → halt with halt_cause=3 after cycle_count=10; burst_len=0 start → immediate halt with cause 4 and no cpu_en.
- Priority: halt_req asserted in the same cycle as a breakpoint match → halt_cause=1; halt_req with start in IDLE → HALT, cause 1, no enabled cycle.
- Reset mid-burst: rst during a burst (burst_len=100, at cycle 20) → next cycle all outputs at reset values; a new start restarts cleanly.
